d_mem_bus: RTL and testbench
============================

D_MEM_BUS -- requirements
Module: d_mem_bus

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, number of word-address bits (depth = 2^ADDR_BITS words of 32 bits).
REQ-002 The block SHALL have parameter LATENCY, default 2, number of cycles from request accept to response (legal range 1..15).
REQ-003 The block SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port Req  input  1  request strobe, sampled only while Ready=1.
REQ-006 The block SHALL have port Ready  output  1  high when the block can accept a request.
REQ-007 The block SHALL have port Address  input  32  byte address.
REQ-008 The block SHALL have port WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 The block SHALL have port MemWrite  input  1  store request.
REQ-010 The block SHALL have port MemRead  input  1  load request.
REQ-011 The block SHALL have port Size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 The block SHALL have port Unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-013 The block SHALL have port ReadData  output  32  registered load result.
REQ-014 The block SHALL have port Valid  output  1  one-cycle response pulse.
REQ-015 The block SHALL have port Fault  output  1  qualifies Valid; request rejected with no side effects.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP; Ready=1 only in IDLE.
REQ-017 Accept: at a rising edge with state IDLE and Req=1, the block SHALL latch Address, WriteData, MemWrite, MemRead, Size and Unsigned, and load the latency counter; later input changes SHALL be ignored until the next accept.
REQ-018 Accept SHALL go to WAIT; WAIT SHALL go to RESP on the edge LATENCY edges after accept; RESP SHALL go to IDLE on the next edge; Valid=1 exactly in RESP.
REQ-019 With LATENCY=1 the FSM SHALL go from accept to RESP on the following edge, with WAIT lasting one cycle.
REQ-020 Req while Ready=0 SHALL be ignored, not queued.
REQ-021 Fault SHALL be set for any of these: MemRead and MemWrite both 1 or both 0; Size=11; half with Address[0]=1; word with Address[1:0]!=0; any of Address[31:ADDR_BITS+2] nonzero.
REQ-022 A faulting request SHALL still take LATENCY cycles, leave memory unchanged, and load ReadData with 0.
REQ-023 A store SHALL write the array on the edge entering RESP. Byte: WriteData[7:0] to lane Address[1:0]. Half: WriteData[15:0] to lanes {Address[1],x}. Word: all lanes. Unwritten lanes SHALL be unchanged.
REQ-024 A load SHALL read the word at Address[ADDR_BITS+1:2] on the edge entering RESP and select the lane by Address[1:0]. It SHALL extend the selected lane to 32 bits per Unsigned (Unsigned ignored for word) and register the result into ReadData.
REQ-025 ReadData SHALL hold its value until the next response; a store response SHALL leave ReadData unchanged.
REQ-026 A load following a store to the same address SHALL return the stored data.

Reset
REQ-027 While Reset_n=0 at an edge: state SHALL become IDLE, Valid=0, Fault=0, ReadData=0 and Ready=1 after the edge.
REQ-028 Reset during WAIT SHALL abort the request with no write and no response.
REQ-029 Memory array contents SHALL NOT be affected by reset.

Structure
REQ-030 Package d_mem_pkg SHALL hold the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the fault-check helper constants.
REQ-031 The byte-lane load-extract/store-merge logic SHALL be one combinational sub-module, d_mem_align.
REQ-032 The array SHALL be a single 32-bit-wide register array indexed by the word address.

Verification (LATENCY=2, ADDR_BITS=10)
REQ-033 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> Valid two edges after each accept; ReadData=0xDEADBEEF; Fault=0.
REQ-034 Store byte 0x80 at 0x11, then load byte 0x11 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word 0x10 -> 0xDEAD80EF.
REQ-035 Store half at 0x13, Size=11, and MemRead=MemWrite=1 -> each gives Valid with Fault=1 and ReadData=0; load word 0x10 is still 0xDEAD80EF.
REQ-036 Load at 0x00001000 -> Fault=1; load at 0x00000FFC -> Fault=0.
REQ-037 Reset_n=0 for one edge in WAIT after accepting store word 0x12345678 at 0x20 -> no Valid, Ready=1, load 0x20 returns the prior value.
REQ-038 Req held high for 10 cycles -> accepts exactly every LATENCY+2 cycles, one Valid per accept, Ready=0 from accept through RESP.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared definitions for the d_mem_bus data-memory slave.
// Holds the access-size encodings, the FSM state type and the request fault check.
package d_mem_pkg;

  // Access size encodings carried on the Size port
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // FSM state encoding. A plain vector is used so older tools can read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Word-address bits sit above the two byte-lane bits
  localparam int LANE_BITS = 2;

  // A request faults when its direction is ambiguous, its size is illegal,
  // it is misaligned for its size, or it addresses beyond the array.
  function automatic logic fault_check(input logic        rd,
                                       input logic        wr,
                                       input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input int          addr_bits);
    logic f;
    f = (rd == wr);
    if (size == SZ_ILL) f = 1'b1;
    if ((size == SZ_HALF) && addr[0]) f = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) f = 1'b1;
    if ((addr >> (addr_bits + LANE_BITS)) != 32'd0) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/d_mem_align.sv
// Byte-lane steering for d_mem_bus: extracts and extends a load lane,
// and merges store data into the existing word for a read-modify-write.
module d_mem_align
  import d_mem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  // Load path: pick the addressed lane, then sign- or zero-extend it
  always_comb begin
    byte_sel    = rd_word_i[{lane_i, 3'b000} +: 8];
    half_sel    = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_data_o = rd_word_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_data_o = rd_word_i;
    endcase
  end

  // Store path: replicate the right-aligned data across lanes and build lane enables
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be        = 4'b0001 << lane_i;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be        = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata_i;
      end
      default: be = 4'b0000;
    endcase
  end

  // Unselected lanes keep the old memory contents
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word_o[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : rd_word_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/d_mem_bus.sv
// Single-port data memory with a fixed-latency request/response handshake.
// One request in flight; faulting requests are timed like normal ones but
// have no side effects and return zero.
module d_mem_bus
  import d_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Req,
  output logic        Ready,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Valid,
  output logic        Fault
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request captured at accept
  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic                 rd_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 flt_q;

  // Response registers
  logic [31:0] rdata_q;
  logic        valid_q;
  logic        fault_q;

  logic [31:0] mem [0:DEPTH-1];

  logic                 accept;
  logic                 finish;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rd_word;
  logic [31:0]          load_data;
  logic [31:0]          store_word;

  assign Ready    = (state_q == ST_IDLE);
  assign accept   = (state_q == ST_IDLE) && Req;
  assign finish   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign idx      = addr_q[ADDR_BITS+1:2];
  assign rd_word  = mem[idx];
  assign ReadData = rdata_q;
  assign Valid    = valid_q;
  assign Fault    = fault_q;

  d_mem_align u_align (
    .rd_word_i    (rd_word),
    .lane_i       (addr_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // Next-state logic: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and response registers; reset drops any in-flight request
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= finish;
      fault_q <= finish & flt_q;
      if (finish) begin
        if (flt_q)     rdata_q <= 32'd0;
        else if (rd_q) rdata_q <= load_data;
      end
    end
  end

  // Capture the request at accept so later input changes are ignored
  always_ff @(posedge Clock) begin
    if (accept) begin
      addr_q  <= Address[ADDR_BITS+1:0];
      wdata_q <= WriteData;
      wr_q    <= MemWrite;
      rd_q    <= MemRead;
      size_q  <= Size;
      uns_q   <= Unsigned;
      flt_q   <= fault_check(MemRead, MemWrite, Size, Address, ADDR_BITS);
    end
  end

  // Array write on the edge entering RESP; contents survive reset
  always_ff @(posedge Clock) begin
    if (Reset_n && finish && wr_q && !flt_q) begin
      mem[idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_d_mem_bus.sv
// Scoreboard bench for d_mem_bus: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever Valid is presented.
module tb_d_mem_bus;

  localparam int LAT = 2;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0;
  logic        Ready;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] ReadData;
  logic        Valid;
  logic        Fault;

  d_mem_bus #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Req       (Req),
    .Ready     (Ready),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Size      (Size),
    .Unsigned  (Unsigned),
    .ReadData  (ReadData),
    .Valid     (Valid),
    .Fault     (Fault)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    logic        f;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  logic [31:0] model_rd = 32'd0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: every Valid must match the oldest outstanding expectation
  always @(negedge Clock) begin
    if (Valid === 1'b1) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("resp cyc=%0d fault=%0b data=%h", cyc, Fault, ReadData);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_fault", {31'd0, Fault}, {31'd0, e.f});
        chk("resp_data", ReadData, e.d);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge Clock);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Issue one request, record the expected response, then scramble inputs
  task automatic do_req(input logic wr, input logic rd, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ef,
                        input logic [31:0] erd);
    exp_t e;
    @(negedge Clock);
    chk("ready_idle", {31'd0, Ready}, 32'd1);
    Req = 1'b1; MemWrite = wr; MemRead = rd; Size = sz; Unsigned = uns;
    Address = addr; WriteData = wdata;
    @(posedge Clock); #1;
    if (ef)      model_rd = 32'd0;
    else if (rd && !wr) model_rd = erd;
    e.cyc = cyc + LAT; e.f = ef; e.d = model_rd;
    sb.push_back(e);
    Req = 1'b0; Address = $urandom; WriteData = $urandom;
    MemWrite = 1'($urandom); MemRead = 1'($urandom); Size = 2'($urandom);
    Unsigned = 1'($urandom);
    #1 chk("ready_busy", {31'd0, Ready}, 32'd0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_valid", {31'd0, Valid}, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    @(negedge Clock) Reset_n = 1'b1;

    // wr rd size uns addr wdata fault expected-load
    do_req(1, 0, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0);
    do_req(0, 1, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF);
    do_req(1, 0, 2'b00, 0, 32'h11,  32'h80,       0, 32'h0);
    do_req(0, 1, 2'b00, 0, 32'h11,  32'h0,        0, 32'hFFFFFF80);
    do_req(0, 1, 2'b00, 1, 32'h11,  32'h0,        0, 32'h00000080);
    do_req(0, 1, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEAD80EF);
    do_req(1, 0, 2'b01, 0, 32'h13,  32'hFFFF,     1, 32'h0);
    do_req(0, 1, 2'b11, 0, 32'h10,  32'h0,        1, 32'h0);
    do_req(1, 1, 2'b10, 0, 32'h10,  32'h11111111, 1, 32'h0);
    do_req(0, 0, 2'b10, 0, 32'h10,  32'h0,        1, 32'h0);
    do_req(0, 1, 2'b10, 0, 32'h12,  32'h0,        1, 32'h0);
    do_req(0, 1, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEAD80EF);
    do_req(0, 1, 2'b01, 0, 32'h12,  32'h0,        0, 32'hFFFFDEAD);
    do_req(0, 1, 2'b01, 1, 32'h12,  32'h0,        0, 32'h0000DEAD);
    do_req(1, 0, 2'b01, 0, 32'h12,  32'hAAAA7F01, 0, 32'h0);
    do_req(0, 1, 2'b10, 0, 32'h10,  32'h0,        0, 32'h7F0180EF);
    do_req(0, 1, 2'b00, 0, 32'h13,  32'h0,        0, 32'h0000007F);
    do_req(0, 1, 2'b10, 0, 32'h1000, 32'h0,       1, 32'h0);
    do_req(1, 0, 2'b10, 0, 32'hFFC, 32'h0BADC0DE, 0, 32'h0);
    do_req(0, 1, 2'b10, 0, 32'hFFC, 32'h0,        0, 32'h0BADC0DE);

    // Reset in WAIT aborts a store
    do_req(1, 0, 2'b10, 0, 32'h20,  32'hCAFEF00D, 0, 32'h0);
    @(negedge Clock);
    Req = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; Size = 2'b10;
    Address = 32'h20; WriteData = 32'h12345678;
    @(posedge Clock); #1 Req = 1'b0;
    @(negedge Clock) Reset_n = 1'b0;
    @(posedge Clock); #1;
    chk("abort_ready", {31'd0, Ready}, 32'd1);
    chk("abort_rdata", ReadData, 32'd0);
    model_rd = 32'd0;
    @(negedge Clock) Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    do_req(0, 1, 2'b10, 0, 32'h20,  32'h0,        0, 32'hCAFEF00D);

    // Req held high for 10 cycles: accepts every LAT+2 cycles
    v0 = n_valid;
    @(negedge Clock);
    Req = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; Size = 2'b10;
    Unsigned = 1'b0; Address = 32'h10;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_ready", {31'd0, Ready}, {31'd0, (i % (LAT + 2)) == 0});
      @(posedge Clock); #1;
      if ((i % (LAT + 2)) == 0) begin
        exp_t e;
        model_rd = 32'h7F0180EF;
        e.cyc = cyc + LAT; e.f = 1'b0; e.d = model_rd;
        sb.push_back(e);
      end
      @(negedge Clock);
    end
    Req = 1'b0;
    drain();
    repeat (3) @(negedge Clock);
    chk("b2b_valid_count", 32'(n_valid - v0), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
